// File: rtl/sw_logic_unit_if.sv
// Switch/LED bus between the board pins and sw_logic_unit.
// master drives sw_a/btn and reads led/load; slave is the logic unit.
interface sw_logic_unit_if;
    logic [31:0] sw_a;
    logic        btn;
    logic [31:0] led;
    logic        load;

    modport master (
        output sw_a,
        output btn,
        input  led,
        input  load
    );

    modport slave (
        input  sw_a,
        input  btn,
        output led,
        output load
    );
endinterface

// File: rtl/sw_logic_unit.sv
// Switch/LED logic unit: sync + debounce switches and button, latch
// op(a,b) on each press, show result and press count on the LEDs.
// Ports: clk, rst (async, active-high), bus (sw_logic_unit_if.slave):
//   sw_a[31:0] in  : a=[W-1:0], b=[2W-1:W], op=[2W+1:2W]
//   btn        in  : load button
//   led[31:0]  out : [W-1:0]=result, [31:24]=press counter
//   load       out : one-cycle pulse per accepted press
// Optional feature macro: SW_LIVE_EN (result also follows the
// debounced switches without a press).

module sw_logic_unit_deb #(
    parameter int N          = 1,
    parameter int DEB_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  cand;
    logic [CW-1:0] cnt;

    // Any change of s2 restarts the count; the counter
    // saturates so stable keeps reloading the same cand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                dout <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module sw_logic_unit #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic             clk,
    input logic             rst,
    sw_logic_unit_if.slave  bus
);
    localparam int NW = 2 * WIDTH + 2;

    logic [31:0]      sw_pin;
    logic             btn_pin;
    logic [NW-1:0]    sw_stable;
    logic [0:0]       btn_stable;
    logic             btn_d;
    logic             load_q;
    logic             live_upd;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] result;
    logic [7:0]       presses;
    logic [31:0]      led_logic;

    assign sw_pin  = ACTIVE_LOW ? ~bus.sw_a : bus.sw_a;
    assign btn_pin = ACTIVE_LOW ? ~bus.btn : bus.btn;

    // Switch bits above the op field carry nothing.
    if (NW < 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^sw_pin[31:NW];
    end

    sw_logic_unit_deb #(
        .N          (NW),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (sw_pin[NW-1:0]),
        .dout (sw_stable)
    );

    sw_logic_unit_deb #(
        .N          (1),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_pin),
        .dout (btn_stable)
    );

    assign op_a   = sw_stable[WIDTH-1:0];
    assign op_b   = sw_stable[2*WIDTH-1:WIDTH];
    assign op_sel = sw_stable[NW-1:2*WIDTH];

    always_comb begin
        op_res = '0;
        unique case (1'b1)
            (op_sel == 2'b00): op_res = op_a & op_b;
            (op_sel == 2'b01): op_res = op_a | op_b;
            (op_sel == 2'b10): op_res = op_a ^ op_b;
            (op_sel == 2'b11): op_res = ~op_a;
        endcase
    end

`ifdef SW_LIVE_EN
    logic [NW-1:0] sw_stable_d;

    // Reload one edge after the debounced switches change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_stable_d <= '0;
        end else begin
            sw_stable_d <= sw_stable;
        end
    end

    assign live_upd = (sw_stable != sw_stable_d);
`else
    assign live_upd = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_d   <= 1'b0;
            load_q  <= 1'b0;
            result  <= '0;
            presses <= '0;
        end else begin
            btn_d  <= btn_stable[0];
            load_q <= btn_stable[0] & ~btn_d;
            if (load_q || live_upd) begin
                result <= op_res;
            end
            if (load_q) begin
                presses <= presses + 8'd1;
            end
        end
    end

    assign led_logic = {presses, {(24 - WIDTH){1'b0}}, result};
    assign bus.led   = ACTIVE_LOW ? ~led_logic : led_logic;
    assign bus.load  = load_q;
endmodule
